// File: rtl/time_display_scanner.sv
// Scans snapshotted hh.mm.ss onto a 6-digit active-low 7-seg display; outputs lag scan state by 1 clk.
// No backpressure: free-running scan, inputs sampled once per frame, mode_select sampled live.
module time_display_scanner #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] hour_in,
    input  logic [5:0] minute_in,
    input  logic [5:0] second_in,
    input  logic [1:0] mode_select,
    input  logic       enable_5hz,
    output logic [5:0] anode,
    output logic [6:0] segment,
    output logic       dp
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0] scan_cnt;
    logic [2:0]    digit_idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [5:0]    snap_hour, snap_minute, snap_second;

    logic          slot_end;
    logic [5:0]    field_val;
    logic          field_bad;
    logic [3:0]    digit_val;
    logic          blanked;
    logic          lit;
    logic [5:0]    anode_next;
    logic [6:0]    segment_next;
    logic          dp_next;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'h40;
            4'd1:    seg_encode = 7'h79;
            4'd2:    seg_encode = 7'h24;
            4'd3:    seg_encode = 7'h30;
            4'd4:    seg_encode = 7'h19;
            4'd5:    seg_encode = 7'h12;
            4'd6:    seg_encode = 7'h02;
            4'd7:    seg_encode = 7'h78;
            4'd8:    seg_encode = 7'h00;
            default: seg_encode = 7'h10;
        endcase
    endfunction

    assign slot_end = (scan_cnt == SW'(SCAN_DIV - 1));

    always_comb begin
        field_val = snap_second;
        field_bad = 1'b0;
        case (digit_idx[2:1])
            2'd0: begin
                field_val = snap_second;
                field_bad = (snap_second > 6'd59);
            end
            2'd1: begin
                field_val = snap_minute;
                field_bad = (snap_minute > 6'd59);
            end
            default: begin
                field_val = snap_hour;
                field_bad = (snap_hour > 6'd23);
            end
        endcase

        digit_val = digit_idx[0] ? 4'(field_val / 6'd10) : 4'(field_val % 6'd10);
        segment_next = field_bad ? 7'h3F : seg_encode(digit_val);

        // mode 01/10/11 selects field 0/1/2, i.e. digit pair (mode-1)
        blanked = blink_phase && (mode_select == (digit_idx[2:1] + 2'd1));
        lit = (scan_cnt != '0) && !blanked;
        anode_next = lit ? (6'h3F ^ (6'd1 << digit_idx)) : 6'h3F;
        dp_next = !(lit && (digit_idx == 3'd2 || digit_idx == 3'd4));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt    <= '0;
            digit_idx   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            snap_hour   <= '0;
            snap_minute <= '0;
            snap_second <= '0;
            anode       <= 6'h3F;
            segment     <= 7'h7F;
            dp          <= 1'b1;
        end else begin
            anode   <= anode_next;
            segment <= segment_next;
            dp      <= dp_next;

            if (slot_end) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end

            // Latch on the last cycle of the frame so the next frame is coherent
            if (slot_end && digit_idx == 3'd5) begin
                snap_hour   <= hour_in;
                snap_minute <= minute_in;
                snap_second <= second_in;
            end

            if (enable_5hz) begin
                if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end
endmodule
